// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM mux/demux pair.
package tdm_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter with enable and synchronous load-to-1; shared by TX and RX sides.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load1,
    output logic [SLOT_W-1:0] o_cnt
);

    logic [SLOT_W-1:0] r_cnt;

    // Load-to-1 wins over increment: a sync sample always occupies slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= SLOT_W'(1);
        end else if (i_en) begin
            r_cnt <= r_cnt + SLOT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: locks to frame_sync and rebuilds four channel samples.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_vld,
    input  logic                   frame_sync,
    output logic [NCH*WIDTH-1:0]   out,
    output logic                   frame_vld,
    output logic [SLOT_W-1:0]      slot,
    output logic                   locked,
    output logic                   sync_err
);

    tdm_state_e          r_state;
    tdm_state_e          w_state_nxt;
    logic [WIDTH-1:0]    r_shadow [0:NCH-2];
    logic [NCH*WIDTH-1:0] r_out;
    logic                r_frame_vld;
    logic                r_sync_err;

    logic                w_wr;
    logic [SLOT_W-1:0]   w_wr_idx;
    logic                w_frame_done;
    logic                w_sync_err;
    logic                w_cnt_en;
    logic                w_load1;
    logic [SLOT_W-1:0]   w_slot;

    // Slot pointer: a valid sync sample reloads to 1, otherwise advance on valid samples while locked.
    assign w_load1  = din_vld & frame_sync;
    assign w_cnt_en = din_vld & (r_state == LOCKED);

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .i_load1 (w_load1),
        .o_cnt   (w_slot)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus per-sample decode: which slot is written, frame completion, misplaced sync.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr         = 1'b0;
        w_wr_idx     = '0;
        w_frame_done = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            HUNT: begin
                if (din_vld && frame_sync) begin
                    w_state_nxt = LOCKED;
                    w_wr        = 1'b1;
                end
            end
            LOCKED: begin
                if (din_vld) begin
                    w_wr = 1'b1;
                    if (frame_sync && (w_slot != '0)) begin
                        // Misplaced sync restarts the frame at slot 0; the partial frame is lost.
                        w_sync_err = 1'b1;
                    end else begin
                        w_wr_idx     = w_slot;
                        w_frame_done = (w_slot == SLOT_W'(NCH - 1));
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Shadow capture for slots 0..2; the slot-3 sample goes straight into the frame register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NCH) - 1; k++) begin
                r_shadow[k] <= '0;
            end
            r_out       <= '0;
            r_frame_vld <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_frame_vld <= w_frame_done;
            r_sync_err  <= w_sync_err;
            if (w_frame_done) begin
                r_out <= {din, r_shadow[2], r_shadow[1], r_shadow[0]};
            end
            for (int k = 0; k < int'(NCH) - 1; k++) begin
                if (w_wr && (w_wr_idx == SLOT_W'(k))) begin
                    r_shadow[k] <= din;
                end
            end
        end
    end

    assign out       = r_out;
    assign frame_vld = r_frame_vld;
    assign slot      = w_slot;
    assign locked    = (r_state == LOCKED);
    assign sync_err  = r_sync_err;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed vector table, WIDTH=8 sequence, randomized run vs. model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       rst, din, din_vld, frame_sync;
    logic [3:0] out;
    logic       frame_vld, locked, sync_err;
    logic [1:0] slot;

    // WIDTH=8 instance
    logic        rst8, vld8, sync8;
    logic [7:0]  din8;
    logic [31:0] out8;
    logic        fv8, lk8, err8;
    logic [1:0]  slot8;

    tdm_demux4 #(.WIDTH(1)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .frame_sync(frame_sync),
        .out(out), .frame_vld(frame_vld), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    tdm_demux4 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .din(din8), .din_vld(vld8), .frame_sync(sync8),
        .out(out8), .frame_vld(fv8), .slot(slot8), .locked(lk8), .sync_err(err8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs applied for one edge, expected outputs just after it.
    typedef struct {
        logic       r, v, s, d;
        logic [3:0] o;
        logic       fv;
        logic [1:0] sl;
        logic       lk, er;
    } vec_t;

    vec_t tv [$];

    task automatic add(input logic r, v, s, d, input logic [3:0] o,
                       input logic fv, input logic [1:0] sl, input logic lk, er);
        vec_t e;
        e.r = r; e.v = v; e.s = s; e.d = d;
        e.o = o; e.fv = fv; e.sl = sl; e.lk = lk; e.er = er;
        tv.push_back(e);
    endtask

    // Reference model: frame assembly from the channel/slot rules, using plain arrays.
    logic       m_locked;
    int         m_slot;
    logic       m_sh [4];
    logic [3:0] m_out;
    logic       m_fv, m_err;

    task automatic model_step(input logic r, v, s, d);
        if (r) begin
            m_locked = 1'b0; m_slot = 0; m_out = '0; m_fv = 1'b0; m_err = 1'b0;
            foreach (m_sh[i]) m_sh[i] = 1'b0;
            return;
        end
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_sh[0] = d; m_slot = 1; m_locked = 1'b1;
            end
        end else if (s && m_slot != 0) begin
            m_err = 1'b1; m_sh[0] = d; m_slot = 1;
        end else begin
            m_sh[m_slot] = d;
            if (m_slot == 3) begin
                for (int c = 0; c < 4; c++) m_out[c] = m_sh[c];
                m_fv = 1'b1;
            end
            m_slot = (m_slot + 1) % 4;
        end
    endtask

    task automatic step(input logic r, v, s, d);
        rst = r; din_vld = v; frame_sync = s; din = d;
        @(posedge clk);
        #1;
        model_step(r, v, s, d);
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_vld = 1'b0; frame_sync = 1'b0;
        rst8 = 1'b1; din8 = '0; vld8 = 1'b0; sync8 = 1'b0;

        //   r  v  s  d   out     fv  slot lk err
        // reset with toggling inputs
        add(1, 0, 0, 1, 4'h0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
        // sync frame 1,0,1,1
        add(0, 1, 1, 1, 4'h0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 4'h0, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'h0, 0, 3, 1, 0);
        add(0, 1, 0, 1, 4'hD, 1, 0, 1, 0);
        add(0, 0, 0, 0, 4'hD, 0, 0, 1, 0);
        // samples before first sync are dropped, then frame 0,0,1,0
        add(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 4'h0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 4'h0, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'h0, 0, 3, 1, 0);
        add(0, 1, 0, 0, 4'h4, 1, 0, 1, 0);
        // back-to-back frames 1,0,0,0 and 0,1,1,1 with valid gaps in the second
        add(0, 1, 1, 1, 4'h4, 0, 1, 1, 0);
        add(0, 1, 0, 0, 4'h4, 0, 2, 1, 0);
        add(0, 1, 0, 0, 4'h4, 0, 3, 1, 0);
        add(0, 1, 0, 0, 4'h1, 1, 0, 1, 0);
        add(0, 1, 1, 0, 4'h1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 4'h1, 0, 1, 1, 0);
        add(0, 0, 1, 1, 4'h1, 0, 1, 1, 0);
        add(0, 1, 0, 1, 4'h1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 4'h1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 4'h1, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'h1, 0, 3, 1, 0);
        add(0, 1, 0, 1, 4'hE, 1, 0, 1, 0);
        add(0, 0, 0, 0, 4'hE, 0, 0, 1, 0);
        // misplaced sync after slot 1, then 1,1,0
        add(0, 1, 1, 0, 4'hE, 0, 1, 1, 0);
        add(0, 1, 0, 1, 4'hE, 0, 2, 1, 0);
        add(0, 1, 1, 1, 4'hE, 0, 1, 1, 1);
        add(0, 1, 0, 1, 4'hE, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'hE, 0, 3, 1, 0);
        add(0, 1, 0, 0, 4'h7, 1, 0, 1, 0);
        // free-running slot 0 without sync
        add(0, 1, 0, 0, 4'h7, 0, 1, 1, 0);
        add(0, 1, 0, 1, 4'h7, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'h7, 0, 3, 1, 0);
        add(0, 1, 0, 1, 4'hE, 1, 0, 1, 0);
        // misplaced sync on slot 3: error, no frame
        add(0, 1, 1, 1, 4'hE, 0, 1, 1, 0);
        add(0, 1, 0, 1, 4'hE, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'hE, 0, 3, 1, 0);
        add(0, 1, 1, 0, 4'hE, 0, 1, 1, 1);
        // reset mid-frame after slot 2 write, then unsynced sample dropped
        add(0, 1, 0, 0, 4'hE, 0, 2, 1, 0);
        add(0, 1, 0, 1, 4'hE, 0, 3, 1, 0);
        add(1, 1, 0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 4'h0, 0, 0, 0, 0);

        foreach (tv[i]) begin
            step(tv[i].r, tv[i].v, tv[i].s, tv[i].d);
            chk($sformatf("vec%0d out", i),       32'(out),       32'(tv[i].o));
            chk($sformatf("vec%0d frame_vld", i), 32'(frame_vld), 32'(tv[i].fv));
            chk($sformatf("vec%0d slot", i),      32'(slot),      32'(tv[i].sl));
            chk($sformatf("vec%0d locked", i),    32'(locked),    32'(tv[i].lk));
            chk($sformatf("vec%0d sync_err", i),  32'(sync_err),  32'(tv[i].er));
        end

        // WIDTH=8 frame A5,3C,FF,01
        @(posedge clk); #1;
        chk("w8 reset out", out8, 32'h0);
        chk("w8 reset locked", 32'(lk8), 32'h0);
        rst8 = 1'b0; vld8 = 1'b1; sync8 = 1'b1; din8 = 8'hA5;
        @(posedge clk); #1;
        chk("w8 slot after sync", 32'(slot8), 32'h1);
        sync8 = 1'b0; din8 = 8'h3C;
        @(posedge clk); #1;
        din8 = 8'hFF;
        @(posedge clk); #1;
        din8 = 8'h01;
        chk("w8 out before last", out8, 32'h0);
        chk("w8 fv before last", 32'(fv8), 32'h0);
        @(posedge clk); #1;
        vld8 = 1'b0;
        chk("w8 out frame", out8, 32'h01FF3CA5);
        chk("w8 frame_vld", 32'(fv8), 32'h1);
        chk("w8 locked", 32'(lk8), 32'h1);
        @(posedge clk); #1;
        chk("w8 fv pulse end", 32'(fv8), 32'h0);
        chk("w8 out hold", out8, 32'h01FF3CA5);

        // Randomized run against the model
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic r, v, s, d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            if (!m_locked || m_slot == 0) s = ($urandom_range(0, 3) != 0);
            else                          s = ($urandom_range(0, 11) == 0);
            d = 1'($urandom);
            step(r, v, s, d);
            chk($sformatf("rnd%0d out", n),       32'(out),       32'(m_out));
            chk($sformatf("rnd%0d frame_vld", n), 32'(frame_vld), 32'(m_fv));
            chk($sformatf("rnd%0d slot", n),      32'(slot),      32'(m_slot));
            chk($sformatf("rnd%0d locked", n),    32'(locked),    32'(m_locked));
            chk($sformatf("rnd%0d sync_err", n),  32'(sync_err),  32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tdm_demux4
